lfsr_noise_source: RTL and testbench
====================================

Name: lfsr_noise_source

Overview:
- Parametrised pseudo-random word generator. It is the successor to the fixed-table LFSR in the data_source IP.
- Runtime-programmable Fibonacci XNOR polynomial, any width 3..32.
- Assembles OUT_BITS serial feedback bits into words and delivers them on a valid/ready handshake, with backpressure stall.
- Adds period-done detection, lock-up recovery and an optional single-cycle parallel mode.
- Feeds test-pattern and noise paths in the signal-processing chain.

Parameters:
- WIDTH, 16, LFSR length in bits. Legal range 3..32.
- OUT_BITS, 8, bits per output word. Legal range 1..32.
- TAPS_RESET, 16'hD008, tap mask loaded at reset. Default is taps 16,15,13,4.

Ports:
- i_Clk  in  1  clock; all logic on rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Enable  in  1  run enable; when low, LFSR state and word assembly freeze.
- i_Seed_DV  in  1  one-cycle pulse that loads seed and taps.
- i_Seed_Data  in  WIDTH  seed value.
- i_Taps  in  WIDTH  tap mask; bit k set means stage k+1 is in the feedback.
- o_Data  out  OUT_BITS  output word.
- o_Valid  out  1  o_Data holds an unconsumed word.
- i_Ready  in  1  consumer accepts the word when o_Valid & i_Ready.
- o_Period_Done  out  1  one-cycle pulse when the state returns to the latched seed.
- o_Lockup  out  1  sticky flag: a lock-up state was detected and recovered.

Behaviour:
- Reset values: state 0, taps TAPS_RESET, latched seed 0, bit count 0, o_Data 0, o_Valid 0, o_Period_Done 0, o_Lockup 0.
- Feedback: fb = XNOR-reduce of (state & taps).
- Step: state <= {state[WIDTH-2:0], fb}.
- Word assembly: word shift register <= {word[OUT_BITS-2:0], fb}, so the first bit produced lands in the MSB.
- FSM states:
  - IDLE: entered at reset. Moves to RUN on the first cycle i_Enable = 1.
  - RUN: one step per enabled cycle; the bit counter runs 0..OUT_BITS-1. On the step that completes a word:
    - If the output register is free (o_Valid = 0, or o_Valid & i_Ready this cycle): transfer the word to o_Data, set o_Valid = 1 next cycle, clear the counter, stay in RUN.
    - Otherwise: go to HOLD with the completed word held internally.
  - HOLD: no stepping. When the output register frees, transfer the held word to o_Data, set o_Valid = 1, return to RUN.
- o_Valid clears on o_Valid & i_Ready unless a new word is transferred in the same cycle. A simultaneous consume and transfer keeps o_Valid = 1 with no bubble.
- Latency and throughput: the first word is valid OUT_BITS+1 cycles after RUN starts. Unstalled rate is one word per OUT_BITS cycles.
- i_Enable = 0 in RUN: no step, counter holds. The handshake still completes, so o_Valid can drop.
- Seed load (i_Seed_DV, ignores i_Enable, highest priority):
  - state <= i_Seed_Data; latched seed and taps <= inputs.
  - Counter, partial word and held word are discarded.
  - o_Valid <= 0, o_Lockup <= 0, FSM to IDLE.
- Period done: o_Period_Done pulses on the cycle after a step whose result equals the latched seed. Never asserted on the load cycle itself.
- Lock-up (XNOR form): state all-ones is the lock-up state.
  - If state is all-ones in RUN, the next cycle forces state <= 0 instead of stepping, sets o_Lockup, and emits no bit.
  - An all-ones seed is therefore recovered on the first RUN cycle.
- Taps = 0: fb is constantly 1, which drives the state into lock-up. This is covered by the recovery above; no other check.
- Asynchronous reset mid-word or mid-HOLD returns all registers to reset values immediately; the partial word is lost.
- Widths are fixed: no truncation, and the counter is sized $clog2(OUT_BITS+1).

Optional Feature:
- Macro: LFSR_NOISE_PARALLEL_EN.
- When defined: a combinational unroll performs OUT_BITS steps per enabled RUN cycle.
  - A complete word is produced every cycle, and the bit counter is removed.
  - o_Period_Done pulses if any intermediate state equals the seed.
  - Lock-up is checked on the entry state only.
- When undefined: the serial one-bit-per-cycle behaviour above. Output words are bit-identical in both modes.

Test Plan:
- WIDTH=4, OUT_BITS=4, taps 4'b1100, seed 0, i_Ready=1, enable -> o_Data 0xE then 0xC. o_Period_Done pulses after 15 steps.
- Same setup, i_Ready=0 for 20 cycles -> o_Valid holds 0xE, FSM parks in HOLD. Release i_Ready -> 0xE then 0xC, nothing skipped or duplicated.
- Seed 4'b1111 -> first RUN cycle forces state 0, o_Lockup=1, no word emitted. A subsequent seed load clears o_Lockup.
- i_Seed_DV pulse mid-word (after 2 bits) with seed 0 -> o_Valid=0, partial word discarded. Next word is 0xE.
- i_Enable toggled 1-0-1 every cycle -> identical word sequence 0xE, 0xC at half rate.
- Assert i_Rst_n low during HOLD -> all outputs 0 immediately. After release, the taps revert to TAPS_RESET.

Source files
------------

// File: rtl/lfsr_noise_source.sv
// rtl/lfsr_noise_source.sv - Programmable XNOR Fibonacci LFSR word generator with valid/ready output
// Define LFSR_NOISE_PARALLEL_EN to produce a full word per enabled cycle instead of one bit.
module lfsr_noise_source #(
  parameter int               WIDTH      = 16,
  parameter int               OUT_BITS   = 8,
  parameter logic [WIDTH-1:0] TAPS_RESET = 16'hD008
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [WIDTH-1:0]    i_Seed_Data,
  input  logic [WIDTH-1:0]    i_Taps,
  output logic [OUT_BITS-1:0] o_Data,
  output logic                o_Valid,
  input  logic                i_Ready,
  output logic                o_Period_Done,
  output logic                o_Lockup
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t              r_fsm;
  state_t              w_fsm_next;
  logic [WIDTH-1:0]    r_state;
  logic [WIDTH-1:0]    r_taps;
  logic [WIDTH-1:0]    r_seed;
  logic [OUT_BITS-1:0] r_hold;
  logic [OUT_BITS-1:0] r_data;
  logic                r_valid;
  logic                r_period_done;
  logic                r_lockup;

  logic                w_lock_state;
  logic                w_consume;
  logic                w_free;
  logic [WIDTH-1:0]    w_step_state;
  logic [OUT_BITS-1:0] w_word_new;
  logic                w_word_last;
  logic                w_seed_hit;
  logic                w_do_step;
  logic                w_do_recover;
  logic                w_load_new;
  logic                w_load_held;
  logic                w_park;

  // All-ones is the one state an XNOR LFSR can never leave on its own.
  assign w_lock_state = &r_state;
  assign w_consume    = r_valid & i_Ready;
  assign w_free       = ~r_valid | i_Ready;

`ifdef LFSR_NOISE_PARALLEL_EN
  // Unrolled OUT_BITS steps; any intermediate state matching the seed counts as a period hit.
  always_comb begin : par_unroll
    logic v_fb;
    w_step_state = r_state;
    w_word_new   = '0;
    w_seed_hit   = 1'b0;
    v_fb         = 1'b0;
    for (int i = 0; i < OUT_BITS; i++) begin
      v_fb         = ~^(w_step_state & r_taps);
      w_word_new   = (w_word_new << 1) | OUT_BITS'(v_fb);
      w_step_state = {w_step_state[WIDTH-2:0], v_fb};
      if (w_step_state == r_seed) begin
        w_seed_hit = 1'b1;
      end
    end
  end

  assign w_word_last = 1'b1;
`else
  localparam int               CNT_W    = $clog2(OUT_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_BITS - 1);

  logic [CNT_W-1:0]    r_cnt;
  logic [OUT_BITS-1:0] r_word;
  logic                w_fb;

  assign w_fb         = ~^(r_state & r_taps);
  assign w_step_state = {r_state[WIDTH-2:0], w_fb};
  assign w_word_new   = (r_word << 1) | OUT_BITS'(w_fb);
  assign w_word_last  = (r_cnt == CNT_LAST);
  assign w_seed_hit   = (w_step_state == r_seed);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_Seed_DV) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (w_do_step) begin
      r_word <= w_word_new;
      r_cnt  <= w_word_last ? '0 : r_cnt + CNT_W'(1);
    end
  end
`endif

  always_comb begin
    w_fsm_next   = r_fsm;
    w_do_step    = 1'b0;
    w_do_recover = 1'b0;
    w_load_new   = 1'b0;
    w_load_held  = 1'b0;
    w_park       = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        if (i_Enable) begin
          w_fsm_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_Enable) begin
          if (w_lock_state) begin
            w_do_recover = 1'b1;
          end else begin
            w_do_step = 1'b1;
            if (w_word_last) begin
              if (w_free) begin
                w_load_new = 1'b1;
              end else begin
                w_park     = 1'b1;
                w_fsm_next = ST_HOLD;
              end
            end
          end
        end
      end
      ST_HOLD: begin
        if (w_free) begin
          w_load_held = 1'b1;
          w_fsm_next  = ST_RUN;
        end
      end
      default: w_fsm_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_fsm         <= ST_IDLE;
      r_state       <= '0;
      r_taps        <= TAPS_RESET;
      r_seed        <= '0;
      r_hold        <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_period_done <= 1'b0;
      r_lockup      <= 1'b0;
    end else if (i_Seed_DV) begin
      r_fsm         <= ST_IDLE;
      r_state       <= i_Seed_Data;
      r_taps        <= i_Taps;
      r_seed        <= i_Seed_Data;
      r_hold        <= '0;
      r_valid       <= 1'b0;
      r_period_done <= 1'b0;
      r_lockup      <= 1'b0;
    end else begin
      r_fsm         <= w_fsm_next;
      r_period_done <= w_do_step & w_seed_hit;
      if (w_do_recover) begin
        r_state  <= '0;
        r_lockup <= 1'b1;
      end else if (w_do_step) begin
        r_state <= w_step_state;
      end
      if (w_park) begin
        r_hold <= w_word_new;
      end
      // A transfer in the same cycle as a consume keeps o_Valid high with no bubble.
      if (w_load_new) begin
        r_data  <= w_word_new;
        r_valid <= 1'b1;
      end else if (w_load_held) begin
        r_data  <= r_hold;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_Data        = r_data;
  assign o_Valid       = r_valid;
  assign o_Period_Done = r_period_done;
  assign o_Lockup      = r_lockup;

endmodule

// File: tb/tb_lfsr_noise_source.sv
// tb/tb_lfsr_noise_source.sv - Self-checking bench for lfsr_noise_source against a bit-stream model
module tb_lfsr_noise_source;

  localparam int         W        = 4;
  localparam int         OB       = 4;
  localparam logic [3:0] TB_TAPS  = 4'b1001;

  logic          i_Clk = 1'b0;
  logic          i_Rst_n;
  logic          i_Enable;
  logic          i_Seed_DV;
  logic [W-1:0]  i_Seed_Data;
  logic [W-1:0]  i_Taps;
  logic [OB-1:0] o_Data;
  logic          o_Valid;
  logic          i_Ready;
  logic          o_Period_Done;
  logic          o_Lockup;

  int checks   = 0;
  int failures = 0;

  logic [OB-1:0] acc[$];

  lfsr_noise_source #(
    .WIDTH(W),
    .OUT_BITS(OB),
    .TAPS_RESET(TB_TAPS)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst_n(i_Rst_n),
    .i_Enable(i_Enable),
    .i_Seed_DV(i_Seed_DV),
    .i_Seed_Data(i_Seed_Data),
    .i_Taps(i_Taps),
    .o_Data(o_Data),
    .o_Valid(o_Valid),
    .i_Ready(i_Ready),
    .o_Period_Done(o_Period_Done),
    .o_Lockup(o_Lockup)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_word(input string nm, input int idx, input logic [OB-1:0] exp);
    if (idx >= acc.size()) begin
      checks++;
      failures++;
      $display("FAIL %s word %0d missing, only %0d words accepted", nm, idx, acc.size());
    end else begin
      check(nm, 32'(acc[idx]), 32'(exp));
    end
  endtask

  // Model: the LFSR is a bit stream chopped into words; completed words wait in a queue
  // until the single output slot is free, and the stream pauses while a word waits.
  logic [W-1:0]  m_lfsr, m_taps, m_seed;
  logic [OB-1:0] m_data, m_w;
  logic          m_valid, m_pd, m_lock, m_run, m_fb, m_free, m_got;
  bit            m_bits[$];
  logic [OB-1:0] m_held[$];

  always @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      m_lfsr = '0; m_taps = TB_TAPS; m_seed = '0; m_data = '0;
      m_valid = 1'b0; m_pd = 1'b0; m_lock = 1'b0; m_run = 1'b0;
      m_bits.delete(); m_held.delete();
    end else begin
      m_free = !m_valid || i_Ready;
      m_got  = 1'b0;
      m_pd   = 1'b0;
      if (i_Seed_DV) begin
        m_lfsr = i_Seed_Data; m_taps = i_Taps; m_seed = i_Seed_Data;
        m_bits.delete(); m_held.delete();
        m_valid = 1'b0; m_lock = 1'b0; m_run = 1'b0;
      end else begin
        if (m_held.size() != 0) begin
          if (m_free) begin
            m_data = m_held.pop_front();
            m_got  = 1'b1;
          end
        end else if (m_run && i_Enable) begin
          if (m_lfsr == {W{1'b1}}) begin
            m_lfsr = '0;
            m_lock = 1'b1;
          end else begin
            m_fb   = (($countones(m_lfsr & m_taps) % 2) == 0);
            m_lfsr = {m_lfsr[W-2:0], m_fb};
            m_pd   = (m_lfsr == m_seed);
            m_bits.push_back(m_fb);
            if (m_bits.size() == OB) begin
              m_w = '0;
              foreach (m_bits[i]) m_w = {m_w[OB-2:0], m_bits[i]};
              m_bits.delete();
              if (m_free) begin
                m_data = m_w;
                m_got  = 1'b1;
              end else begin
                m_held.push_back(m_w);
              end
            end
          end
        end
        if (i_Enable) m_run = 1'b1;
        if (m_got) m_valid = 1'b1;
        else if (m_valid && i_Ready) m_valid = 1'b0;
      end
    end
  end

  always @(negedge i_Clk) begin
    if (i_Rst_n) begin
      check("cyc_data", 32'(o_Data), 32'(m_data));
      check("cyc_valid", 32'(o_Valid), 32'(m_valid));
      check("cyc_period_done", 32'(o_Period_Done), 32'(m_pd));
      check("cyc_lockup", 32'(o_Lockup), 32'(m_lock));
      if (o_Valid && i_Ready) acc.push_back(o_Data);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_Clk);
      #2;
    end
  endtask

  task automatic load(input logic [W-1:0] seed, input logic [W-1:0] taps);
    i_Enable    = 1'b0;
    i_Seed_DV   = 1'b1;
    i_Seed_Data = seed;
    i_Taps      = taps;
    step(1);
    i_Seed_DV = 1'b0;
    acc.delete();
  endtask

  int first_v, first_pd;

  initial begin
    i_Rst_n = 1'b0; i_Enable = 1'b0; i_Seed_DV = 1'b0;
    i_Seed_Data = '0; i_Taps = '0; i_Ready = 1'b0;
    #3;
    check("rst_data", 32'(o_Data), 32'h0);
    check("rst_valid", 32'(o_Valid), 32'h0);
    check("rst_period_done", 32'(o_Period_Done), 32'h0);
    check("rst_lockup", 32'(o_Lockup), 32'h0);
    step(3);
    i_Rst_n = 1'b1;
    step(2);

    // Basic stream, latency and period
    load(4'h0, 4'b1100);
    i_Enable = 1'b1; i_Ready = 1'b1;
    first_v = 0; first_pd = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge i_Clk);
      @(negedge i_Clk);
      if (o_Valid && first_v == 0) first_v = k;
      if (o_Period_Done && first_pd == 0) first_pd = k;
    end
    check("first_valid_edge", 32'(first_v), 32'd5);
    check("first_period_edge", 32'(first_pd), 32'd16);
    expect_word("basic_w0", 0, 4'hE);
    expect_word("basic_w1", 1, 4'hC);

    // Backpressure parks the next word in HOLD
    load(4'h0, 4'b1100);
    i_Enable = 1'b1; i_Ready = 1'b0;
    step(20);
    @(negedge i_Clk);
    check("hold_valid", 32'(o_Valid), 32'h1);
    check("hold_data", 32'(o_Data), 32'hE);
    step(1);
    i_Ready = 1'b1;
    step(12);
    expect_word("hold_w0", 0, 4'hE);
    expect_word("hold_w1", 1, 4'hC);
    expect_word("hold_w2", 2, 4'hA);

    // All-ones seed recovers to zero and flags lock-up
    load(4'hF, 4'b1100);
    i_Enable = 1'b1; i_Ready = 1'b1;
    step(2);
    @(negedge i_Clk);
    check("lock_flag", 32'(o_Lockup), 32'h1);
    check("lock_no_word", 32'(o_Valid), 32'h0);
    step(8);
    expect_word("lock_w0", 0, 4'hE);
    load(4'h0, 4'b1100);
    @(negedge i_Clk);
    check("lock_cleared", 32'(o_Lockup), 32'h0);

    // Seed reload after two bits discards the partial word
    load(4'h0, 4'b1100);
    i_Enable = 1'b1; i_Ready = 1'b1;
    step(3);
    i_Seed_DV = 1'b1; i_Seed_Data = 4'h0; i_Taps = 4'b1100;
    step(1);
    i_Seed_DV = 1'b0;
    acc.delete();
    @(negedge i_Clk);
    check("midword_valid", 32'(o_Valid), 32'h0);
    step(12);
    expect_word("midword_w0", 0, 4'hE);

    // Enable toggling halves the rate without changing the words
    load(4'h0, 4'b1100);
    i_Ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      i_Enable = (i % 2 == 0);
      step(1);
    end
    expect_word("toggle_w0", 0, 4'hE);
    expect_word("toggle_w1", 1, 4'hC);

    // Reset during HOLD, then reset taps are back in effect
    load(4'h0, 4'b1100);
    i_Enable = 1'b1; i_Ready = 1'b0;
    step(15);
    i_Rst_n = 1'b0;
    #1;
    check("hold_rst_data", 32'(o_Data), 32'h0);
    check("hold_rst_valid", 32'(o_Valid), 32'h0);
    check("hold_rst_period_done", 32'(o_Period_Done), 32'h0);
    check("hold_rst_lockup", 32'(o_Lockup), 32'h0);
    step(2);
    i_Rst_n = 1'b1;
    acc.delete();
    i_Ready = 1'b1;
    step(20);
    expect_word("rst_taps_w0", 0, 4'hA);
    expect_word("rst_taps_w1", 1, 4'h6);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      i_Ready  = ($urandom_range(0, 9) < 7);
      i_Enable = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 99) == 0) begin
        i_Seed_DV   = 1'b1;
        i_Seed_Data = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        i_Taps      = 4'($urandom_range(0, 15));
      end else begin
        i_Seed_DV = 1'b0;
      end
      if ($urandom_range(0, 599) == 0) begin
        i_Rst_n = 1'b0;
        step(1);
        i_Rst_n = 1'b1;
      end
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
